// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory sequencer: stalls the PC for loads/stores, runs the req/ack handshake.
// Optional BUSY timeout/abort enabled by defining MEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite_in,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic              stall,
  output logic              RegWrite_out,
  output logic [DATA_W-1:0] ReadData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stall_cycles,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic   mem_op;
  logic   timeout_hit;
  logic   abort_flag;

  assign mem_op = MemRead | MemWrite;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             abort_q;
  logic             err_q;

  // Counter is held at zero outside BUSY, so it always starts from 0 on entry.
  assign timeout_hit = (state == BUSY) && !mem_ack && (busy_cnt == CNT_W'(TIMEOUT - 1));
  assign abort_flag  = abort_q;
  assign err         = err_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      busy_cnt <= '0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      busy_cnt <= (state == BUSY) ? busy_cnt + 1'b1 : '0;
      if (timeout_hit) begin
        abort_q <= 1'b1;
        err_q   <= 1'b1;
      end else if (state == DONE) begin
        abort_q <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign abort_flag  = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    RegWrite_out = 1'b0;
    mem_req      = 1'b0;
    case (state)
      IDLE: begin
        stall        = mem_op;
        RegWrite_out = RegWrite_in & ~mem_op;
        if (mem_op) state_nxt = BUSY;
      end
      BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        RegWrite_out = RegWrite_in & ~abort_flag;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset overrides the combinational outputs so the datapath sees no stall/write during reset.
    if (Reset) begin
      stall        = 1'b0;
      RegWrite_out = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ReadData     <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mem_op) begin
        mem_addr  <= ALUResult;
        mem_wdata <= WriteData;
        mem_we    <= MemWrite;
      end
      if (state == BUSY) begin
        if (mem_ack && !mem_we) ReadData <= mem_rdata;
        else if (timeout_hit)   ReadData <= '0;
      end
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: cycle-by-cycle trace table plus reset/timeout sequences.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic        MemRead, MemWrite, RegWrite_in;
  logic [31:0] ALUResult, WriteData;
  logic        stall, RegWrite_out;
  logic [31:0] ReadData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] stall_cycles;
  logic        err;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .Reset(Reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite_in(RegWrite_in),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .stall(stall), .RegWrite_out(RegWrite_out), .ReadData(ReadData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_cycles(stall_cycles), .err(err)
  );

  typedef struct {
    logic        rd, wr, rwi;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall, e_rwo, e_req, e_we;
    logic [31:0] e_maddr, e_mwd, e_rdout, e_sc;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic rwi,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic ack, input logic [31:0] rdata,
    input logic e_stall, input logic e_rwo, input logic e_req, input logic e_we,
    input logic [31:0] e_maddr, input logic [31:0] e_mwd,
    input logic [31:0] e_rdout, input logic [31:0] e_sc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rwi = rwi; v.addr = addr; v.wdata = wdata;
    v.ack = ack; v.rdata = rdata;
    v.e_stall = e_stall; v.e_rwo = e_rwo; v.e_req = e_req; v.e_we = e_we;
    v.e_maddr = e_maddr; v.e_mwd = e_mwd; v.e_rdout = e_rdout; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic rwi,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ack, input logic [31:0] rdata);
    MemRead = rd; MemWrite = wr; RegWrite_in = rwi;
    ALUResult = addr; WriteData = wdata; mem_ack = ack; mem_rdata = rdata;
  endtask

  initial begin
    logic hang_ok;
    //          rd wr rwi addr          wdata         ack rdata         stl rwo req we  maddr         mwd           rdout         sc
    tbl[0]  = mk(0, 0, 1, 32'h55,       32'h66,       0, 32'h0,        0,  1,  0,  0,  32'h0,        32'h0,        32'h0,        32'd0);
    tbl[1]  = mk(0, 0, 1, 32'h55,       32'h66,       1, 32'hBAD,      0,  1,  0,  0,  32'h0,        32'h0,        32'h0,        32'd0);
    tbl[2]  = mk(1, 0, 1, 32'h100,      32'h0,        0, 32'h0,        1,  0,  0,  0,  32'h0,        32'h0,        32'h0,        32'd0);
    tbl[3]  = mk(1, 0, 1, 32'h100,      32'h0,        0, 32'h0,        1,  0,  1,  0,  32'h100,      32'h0,        32'h0,        32'd1);
    tbl[4]  = mk(1, 0, 1, 32'h100,      32'h0,        0, 32'h0,        1,  0,  1,  0,  32'h100,      32'h0,        32'h0,        32'd2);
    tbl[5]  = mk(1, 0, 1, 32'h100,      32'h0,        1, 32'hDEADBEEF, 1,  0,  1,  0,  32'h100,      32'h0,        32'h0,        32'd3);
    tbl[6]  = mk(1, 0, 1, 32'h100,      32'h0,        0, 32'h0,        0,  1,  0,  0,  32'h100,      32'h0,        32'hDEADBEEF, 32'd4);
    tbl[7]  = mk(0, 1, 0, 32'h20,       32'h12345678, 0, 32'h0,        1,  0,  0,  0,  32'h100,      32'h0,        32'hDEADBEEF, 32'd4);
    tbl[8]  = mk(0, 1, 0, 32'h20,       32'h12345678, 1, 32'hCAFEF00D, 1,  0,  1,  1,  32'h20,       32'h12345678, 32'hDEADBEEF, 32'd5);
    tbl[9]  = mk(0, 1, 0, 32'h20,       32'h12345678, 0, 32'h0,        0,  0,  0,  1,  32'h20,       32'h12345678, 32'hDEADBEEF, 32'd6);
    tbl[10] = mk(1, 0, 1, 32'h40,       32'h0,        0, 32'h0,        1,  0,  0,  1,  32'h20,       32'h12345678, 32'hDEADBEEF, 32'd6);
    tbl[11] = mk(1, 0, 1, 32'h40,       32'h0,        1, 32'h1,        1,  0,  1,  0,  32'h40,       32'h0,        32'hDEADBEEF, 32'd7);
    tbl[12] = mk(1, 0, 1, 32'h40,       32'h0,        0, 32'h0,        0,  1,  0,  0,  32'h40,       32'h0,        32'h1,        32'd8);
    tbl[13] = mk(1, 0, 1, 32'h44,       32'h0,        0, 32'h0,        1,  0,  0,  0,  32'h40,       32'h0,        32'h1,        32'd8);
    tbl[14] = mk(1, 0, 1, 32'h44,       32'h0,        1, 32'h2,        1,  0,  1,  0,  32'h44,       32'h0,        32'h1,        32'd9);
    tbl[15] = mk(1, 0, 1, 32'h44,       32'h0,        1, 32'h77,       0,  1,  0,  0,  32'h44,       32'h0,        32'h2,        32'd10);
    tbl[16] = mk(0, 0, 1, 32'h44,       32'h0,        0, 32'h0,        0,  1,  0,  0,  32'h44,       32'h0,        32'h2,        32'd10);
    tbl[17] = mk(1, 1, 0, 32'h80,       32'hA5A5A5A5, 0, 32'h0,        1,  0,  0,  0,  32'h44,       32'h0,        32'h2,        32'd10);
    tbl[18] = mk(1, 1, 0, 32'h80,       32'hA5A5A5A5, 1, 32'h99,       1,  0,  1,  1,  32'h80,       32'hA5A5A5A5, 32'h2,        32'd11);
    tbl[19] = mk(1, 1, 0, 32'h80,       32'hA5A5A5A5, 0, 32'h0,        0,  0,  0,  1,  32'h80,       32'hA5A5A5A5, 32'h2,        32'd12);
    tbl[20] = mk(0, 0, 0, 32'h80,       32'hA5A5A5A5, 0, 32'h0,        0,  0,  0,  1,  32'h80,       32'hA5A5A5A5, 32'h2,        32'd12);

    // Reset state, with a load presented to prove stall/RegWrite_out are forced low.
    Reset = 1'b1;
    drive(1, 0, 1, 32'h10, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.rwo", 32'(RegWrite_out), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.wdata", mem_wdata, 32'h0);
    chk("rst.rdata", ReadData, 32'h0);
    chk("rst.sc", stall_cycles, 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].rd, tbl[i].wr, tbl[i].rwi, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].rdata);
      #1;
      chk($sformatf("v%0d.stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d.rwo", i), 32'(RegWrite_out), 32'(tbl[i].e_rwo));
      chk($sformatf("v%0d.req", i), 32'(mem_req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d.we", i), 32'(mem_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d.addr", i), mem_addr, tbl[i].e_maddr);
      chk($sformatf("v%0d.wdata", i), mem_wdata, tbl[i].e_mwd);
      chk($sformatf("v%0d.rdata", i), ReadData, tbl[i].e_rdout);
      chk($sformatf("v%0d.sc", i), stall_cycles, tbl[i].e_sc);
      chk($sformatf("v%0d.err", i), 32'(err), 32'd0);
    end

    // Reset in the middle of BUSY, then a late ack after release.
    @(negedge clk);
    drive(1, 0, 1, 32'h200, 32'h0, 0, 32'h0);
    #1 chk("mid.idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1 chk("mid.busy_req", 32'(mem_req), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("mid.req", 32'(mem_req), 32'd0);
    chk("mid.stall", 32'(stall), 32'd0);
    chk("mid.rwo", 32'(RegWrite_out), 32'd0);
    chk("mid.addr", mem_addr, 32'h0);
    chk("mid.rdata", ReadData, 32'h0);
    chk("mid.sc", stall_cycles, 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    drive(0, 0, 1, 32'h0, 32'h0, 1, 32'h1234);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late.req", 32'(mem_req), 32'd0);
    chk("late.stall", 32'(stall), 32'd0);
    chk("late.rwo", 32'(RegWrite_out), 32'd1);
    chk("late.rdata", ReadData, 32'h0);

    // Prime ReadData with a nonzero value, then issue a load that never gets an ack.
    @(negedge clk);
    drive(1, 0, 1, 32'h300, 32'h0, 0, 32'h0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A;
    @(negedge clk);
    mem_ack = 1'b0;
    #1 chk("prime.rdata", ReadData, 32'h5A5A);
    @(negedge clk);
    ALUResult = 32'h304;
    #1 chk("to.idle_stall", 32'(stall), 32'd1);
`ifdef MEM_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("to.busy%0d.req", k), 32'(mem_req), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("to.done.req", 32'(mem_req), 32'd0);
    chk("to.done.stall", 32'(stall), 32'd0);
    chk("to.done.rdata", ReadData, 32'h0);
    chk("to.done.rwo", 32'(RegWrite_out), 32'd0);
    chk("to.done.err", 32'(err), 32'd1);
    @(negedge clk);
    drive(0, 0, 1, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk("to.after.err", 32'(err), 32'd1);
    chk("to.after.rwo", 32'(RegWrite_out), 32'd1);
    @(negedge clk);
    #1 chk("to.sticky.err", 32'(err), 32'd1);
    Reset = 1'b1;
    #1 chk("to.rst.err", 32'(err), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
`else
    hang_ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (stall !== 1'b1 || mem_req !== 1'b1 || err !== 1'b0) hang_ok = 1'b0;
    end
    chk("hang.stall_req", 32'(hang_ok), 32'd1);
    chk("hang.err", 32'(err), 32'd0);
    Reset = 1'b1;
    #1 chk("hang.rst.req", 32'(mem_req), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Multi-cycle data-memory sequencer between the single-cycle RISC-V datapath and a data memory with variable latency and a req/ack handshake. On a load or store it raises stall, which holds the PC through the datapath's PC-hold mux. It drives the memory handshake, captures read data and releases the instruction with a single commit cycle. Non-memory instructions pass through with zero added latency.

Parameters:
ADDR_W, 32, width of data-memory byte address
DATA_W, 32, data word width
TIMEOUT, 64, maximum BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  core clock, rising edge
Reset  input  1  asynchronous, active-high reset
MemRead  input  1  decoded load (ResultSrc==2'b01)
MemWrite  input  1  decoded store
RegWrite_in  input  1  RegWrite from control unit
ALUResult  input  ADDR_W  effective address from datapath
WriteData  input  DATA_W  store data from datapath (RD2)
stall  output  1  to datapath stall input; 1 = hold PC
RegWrite_out  output  1  gated RegWrite to register file
ReadData  output  DATA_W  load data to datapath result mux
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  registered address
mem_wdata  output  DATA_W  registered store data
mem_ack  input  1  one-cycle completion pulse from memory
mem_rdata  input  DATA_W  read data, valid with mem_ack
stall_cycles  output  32  saturating count of stalled cycles
err  output  1  sticky abort flag (0 unless MEM_TIMEOUT_EN)

Behaviour:
- Reset (async): state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, ReadData, stall_cycles, err all 0. stall=0 and RegWrite_out=0 while Reset is high.
- mem_op = MemRead | MemWrite. MemRead and MemWrite together is treated as a store (MemWrite wins).
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = mem_op (combinational).
  - RegWrite_out = RegWrite_in & ~mem_op.
  - If mem_op: latch ALUResult->mem_addr, WriteData->mem_wdata, MemWrite->mem_we; go to BUSY.
- BUSY:
  - mem_req=1, stall=1, RegWrite_out=0.
  - On mem_ack: if !mem_we, capture mem_rdata->ReadData; go to DONE.
  - No ack: remain in BUSY.
- DONE:
  - mem_req=0, stall=0.
  - RegWrite_out = RegWrite_in & ~abort_flag; ReadData stays stable through this cycle.
  - Go to IDLE unconditionally. The PC advances at the end of DONE.
- Latency: a memory instruction occupies 3 + N cycles, where N is the number of BUSY cycles before ack (N=0 when ack arrives in the first BUSY cycle). Non-memory instructions take 1 cycle.
- Back-to-back memory instructions: IDLE re-detects mem_op on the cycle after DONE. There is no skip of IDLE.
- ReadData holds its last captured value until the next load ack. Stores never modify it.
- mem_ack in IDLE or DONE is ignored.
- mem_addr, mem_wdata and mem_we are stable for the whole BUSY period.
- stall_cycles increments on every cycle stall=1 and saturates at 0xFFFFFFFF.
- Reset mid-BUSY: mem_req drops immediately (async). The outstanding access is abandoned, and a late ack after reset is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A BUSY-cycle counter starts at 0 on BUSY entry.
  - If it reaches TIMEOUT without ack: abort_flag=1, ReadData forced to 0, go to DONE. DONE suppresses RegWrite_out.
  - err is set sticky, cleared only by Reset.
  - abort_flag clears on DONE exit.
- Undefined: BUSY waits indefinitely, err is tied 0, and no timeout counter is synthesised.

Test Plan:
1. ALU instruction (MemRead=0, MemWrite=0, RegWrite_in=1) -> stall=0, RegWrite_out=1 same cycle, mem_req never asserts, stall_cycles stays 0.
2. Load, ALUResult=0x100, ack 2 cycles into BUSY with mem_rdata=0xDEADBEEF:
   - mem_req=1 for 3 cycles, mem_we=0, mem_addr=0x100.
   - DONE: ReadData=0xDEADBEEF, RegWrite_out=1, stall=0.
   - stall_cycles=4.
3. Store, ALUResult=0x20, WriteData=0x12345678, ack in first BUSY cycle -> mem_we=1, mem_wdata=0x12345678 for one cycle, DONE has RegWrite_out=0, ReadData unchanged, total 3 cycles.
4. Two consecutive loads (acks immediate, data 0x1 then 0x2) -> two full IDLE-BUSY-DONE sequences, ReadData=0x1 then 0x2 in respective DONE cycles, PC held except on DONE cycles.
5. Reset asserted mid-BUSY, then ack pulse after release -> mem_req=0 immediately, state IDLE, ack ignored, all outputs at reset values.
6. With MEM_TIMEOUT_EN, TIMEOUT=4, load with no ack -> after 4 BUSY cycles DONE with ReadData=0, RegWrite_out=0, err=1 persisting until Reset. Without the macro: stall stays 1 indefinitely, err=0.
